// File: rtl/hsid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hsid_pkg
//  Description : Shared constants and types for the HSID pixel classification
//                datapath (MSE lane arbiter sequencing state, default sizes).
//  Revision    : 1.0 - initial release
// ============================================================================
package hsid_pkg;

    // Default datapath sizes
    localparam int HSID_WORD_WIDTH      = 32;
    localparam int HSID_MAX_HSP_LIBRARY = 16;
    localparam int HSID_MSE_ARB_LANES   = 4;

    // Per-pixel sequencing states of the MSE arbiter
    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_CLEAR = 3'd1,
        ARB_RUN   = 3'd2,
        ARB_DRAIN = 3'd3,
        ARB_DONE  = 3'd4
    } hsid_mse_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/hsid_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : hsid_rr_arbiter
//  Description : Round-robin arbiter. The search starts at the lane after the
//                last lane whose grant was consumed (advance=1). Grant is
//                combinational and one-hot (or zero when nobody requests).
//  Revision    : 1.0 - initial release
// ============================================================================
module hsid_rr_arbiter #(
    parameter int NUM_LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LANES-1:0] req,
    input  logic                 advance,
    output logic [NUM_LANES-1:0] grant
);

    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     w_next_ptr;
    logic [PTR_W-1:0]     w_idx;
    logic [NUM_LANES-1:0] w_grant;
    logic                 w_found;
    int                   w_pos;

    // Scan lanes starting at the pointer, wrapping, and pick the first requester
    always_comb begin
        w_grant    = '0;
        w_next_ptr = r_ptr;
        w_found    = 1'b0;
        w_pos      = 0;
        w_idx      = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_pos = int'(r_ptr) + i;
            if (w_pos >= NUM_LANES) begin
                w_pos = w_pos - NUM_LANES;
            end
            w_idx = PTR_W'(w_pos);
            if (!w_found && req[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_next_ptr     = (w_pos == NUM_LANES - 1) ? '0 : PTR_W'(w_pos + 1);
            end
        end
    end

    // Pointer moves past the winner only when its transfer actually completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= w_next_ptr;
        end
    end

    assign grant = w_grant;

endmodule
`default_nettype wire

// File: rtl/hsid_mse_arb.sv
`default_nettype none
// ============================================================================
//  Module      : hsid_mse_arb
//  Description : Per-pixel sequencer in front of the MSE min/max comparator.
//                Clears the comparator, feeds it lib_size results collected
//                round-robin from NUM_LANES MSE lanes, waits two cycles for
//                the comparator to settle and latches the classification.
//                Optional macro HSID_MSE_ARB_PERF_EN enables the per-pixel
//                cycle counter on perf_cycles (tied to 0 otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module hsid_mse_arb
    import hsid_pkg::*;
#(
    parameter  int WORD_WIDTH       = HSID_WORD_WIDTH,
    parameter  int HSI_LIBRARY_SIZE = HSID_MAX_HSP_LIBRARY,
    parameter  int NUM_LANES        = HSID_MSE_ARB_LANES,
    localparam int ADDR_W           = $clog2(HSI_LIBRARY_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ADDR_W:0]                lib_size,
    output logic                           busy,
    output logic                           done,
    input  logic [NUM_LANES-1:0]           lane_valid,
    output logic [NUM_LANES-1:0]           lane_ready,
    input  logic [NUM_LANES*WORD_WIDTH-1:0] lane_value,
    input  logic [NUM_LANES*ADDR_W-1:0]    lane_ref,
    output logic                           cmp_clear,
    output logic                           cmp_in_valid,
    output logic [WORD_WIDTH-1:0]          cmp_in_value,
    output logic [ADDR_W-1:0]              cmp_in_ref,
    input  logic                           cmp_out_valid,
    input  logic [WORD_WIDTH-1:0]          cmp_min_value,
    input  logic [WORD_WIDTH-1:0]          cmp_max_value,
    input  logic [ADDR_W-1:0]              cmp_min_ref,
    input  logic [ADDR_W-1:0]              cmp_max_ref,
    output logic [WORD_WIDTH-1:0]          res_min_value,
    output logic [WORD_WIDTH-1:0]          res_max_value,
    output logic [ADDR_W-1:0]              res_min_ref,
    output logic [ADDR_W-1:0]              res_max_ref,
    output logic                           res_err,
    output logic [31:0]                    perf_cycles
);

    localparam logic [ADDR_W:0] c_lib_max = (ADDR_W + 1)'(HSI_LIBRARY_SIZE);

    hsid_mse_arb_state_t   r_state;
    logic [ADDR_W:0]       r_lib;
    logic [ADDR_W:0]       r_count;
    logic                  r_drain;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_cmp_clear;
    logic                  r_cmp_in_valid;
    logic [WORD_WIDTH-1:0] r_cmp_in_value;
    logic [ADDR_W-1:0]     r_cmp_in_ref;
    logic [WORD_WIDTH-1:0] r_res_min_value;
    logic [WORD_WIDTH-1:0] r_res_max_value;
    logic [ADDR_W-1:0]     r_res_min_ref;
    logic [ADDR_W-1:0]     r_res_max_ref;

    logic [NUM_LANES-1:0]  w_req;
    logic [NUM_LANES-1:0]  w_grant;
    logic                  w_xfer;
    logic                  w_accept;
    logic [WORD_WIDTH-1:0] w_sel_value;
    logic [ADDR_W-1:0]     w_sel_ref;
    logic [ADDR_W:0]       w_lib_sat;
    logic                  w_lib_err;
    logic [ADDR_W:0]       w_count_nxt;

    // The comparator output is consumed on a fixed two-cycle drain, so its
    // valid flag carries no extra information here.
    logic w_unused_cmp_out_valid;
    assign w_unused_cmp_out_valid = cmp_out_valid;

    // Lanes may only be granted while collecting results
    assign w_req       = lane_valid & {NUM_LANES{r_state == ARB_RUN}};
    assign w_xfer      = |w_grant;
    assign w_accept    = start && ((r_state == ARB_IDLE) || (r_state == ARB_DONE));
    assign w_lib_err   = (lib_size == '0) || (lib_size > c_lib_max);
    assign w_lib_sat   = (lib_size > c_lib_max) ? c_lib_max : lib_size;
    assign w_count_nxt = r_count + 1'b1;

    hsid_rr_arbiter #(
        .NUM_LANES (NUM_LANES)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_req),
        .advance (w_xfer),
        .grant   (w_grant)
    );

    // One-hot select of the granted lane's value and reference
    always_comb begin
        w_sel_value = '0;
        w_sel_ref   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_grant[i]) begin
                w_sel_value = w_sel_value | lane_value[i*WORD_WIDTH +: WORD_WIDTH];
                w_sel_ref   = w_sel_ref   | lane_ref[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Pixel sequencing FSM with registered comparator controls and results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ARB_IDLE;
            r_lib           <= '0;
            r_count         <= '0;
            r_drain         <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            r_cmp_clear     <= 1'b0;
            r_cmp_in_valid  <= 1'b0;
            r_cmp_in_value  <= '0;
            r_cmp_in_ref    <= '0;
            r_res_min_value <= '1;
            r_res_max_value <= '0;
            r_res_min_ref   <= '0;
            r_res_max_ref   <= '0;
        end else begin
            r_cmp_clear    <= 1'b0;
            r_cmp_in_valid <= 1'b0;
            r_done         <= 1'b0;
            case (r_state)
                ARB_IDLE, ARB_DONE: begin
                    if (w_accept) begin
                        r_lib       <= w_lib_sat;
                        r_count     <= '0;
                        r_err       <= w_lib_err;
                        r_cmp_clear <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ARB_CLEAR;
                    end
                end
                ARB_CLEAR: begin
                    if (r_lib == '0) begin
                        // Nothing to compare: report the cleared comparator state
                        r_res_min_value <= '1;
                        r_res_max_value <= '0;
                        r_res_min_ref   <= '0;
                        r_res_max_ref   <= '0;
                        r_done          <= 1'b1;
                        r_busy          <= 1'b0;
                        r_state         <= ARB_DONE;
                    end else begin
                        r_state <= ARB_RUN;
                    end
                end
                ARB_RUN: begin
                    if (w_xfer) begin
                        r_cmp_in_valid <= 1'b1;
                        r_cmp_in_value <= w_sel_value;
                        r_cmp_in_ref   <= w_sel_ref;
                        r_count        <= w_count_nxt;
                        if (w_count_nxt == r_lib) begin
                            r_drain <= 1'b0;
                            r_state <= ARB_DRAIN;
                        end
                    end
                end
                ARB_DRAIN: begin
                    // First cycle: cmp_in register in flight; second: comparator output settled
                    if (r_drain) begin
                        r_res_min_value <= cmp_min_value;
                        r_res_max_value <= cmp_max_value;
                        r_res_min_ref   <= cmp_min_ref;
                        r_res_max_ref   <= cmp_max_ref;
                        r_done          <= 1'b1;
                        r_busy          <= 1'b0;
                        r_drain         <= 1'b0;
                        r_state         <= ARB_DONE;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

`ifdef HSID_MSE_ARB_PERF_EN
    logic [31:0] r_perf;

    // Count every cycle spent in CLEAR/RUN/DRAIN, saturating, restarted per pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf <= '0;
        end else if (w_accept) begin
            r_perf <= '0;
        end else if (((r_state == ARB_CLEAR) || (r_state == ARB_RUN) || (r_state == ARB_DRAIN))
                     && (r_perf != '1)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`else
    assign perf_cycles = '0;
`endif

    assign busy          = r_busy;
    assign done          = r_done;
    assign lane_ready    = w_grant;
    assign cmp_clear     = r_cmp_clear;
    assign cmp_in_valid  = r_cmp_in_valid;
    assign cmp_in_value  = r_cmp_in_value;
    assign cmp_in_ref    = r_cmp_in_ref;
    assign res_min_value = r_res_min_value;
    assign res_max_value = r_res_max_value;
    assign res_min_ref   = r_res_min_ref;
    assign res_max_ref   = r_res_max_ref;
    assign res_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hsid_mse_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hsid_mse_arb
//  Description : Scoreboard bench for hsid_mse_arb with a behavioural min/max
//                comparator and queue-driven MSE lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hsid_mse_arb;

    localparam int W  = 32;
    localparam int LS = 16;
    localparam int NL = 4;
    localparam int AW = 4;

    typedef struct {
        logic [W-1:0]  v;
        logic [AW-1:0] r;
    } item_t;

    typedef struct {
        logic [W-1:0]  min_v;
        logic [W-1:0]  max_v;
        logic [AW-1:0] min_r;
        logic [AW-1:0] max_r;
        logic          err;
    } res_t;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [AW:0]         lib_size;
    logic                busy;
    logic                done;
    logic [NL-1:0]       lane_valid;
    logic [NL-1:0]       lane_ready;
    logic [NL*W-1:0]     lane_value;
    logic [NL*AW-1:0]    lane_ref;
    logic                cmp_clear;
    logic                cmp_in_valid;
    logic [W-1:0]        cmp_in_value;
    logic [AW-1:0]       cmp_in_ref;
    logic                cmp_out_valid;
    logic [W-1:0]        cmp_min_value;
    logic [W-1:0]        cmp_max_value;
    logic [AW-1:0]       cmp_min_ref;
    logic [AW-1:0]       cmp_max_ref;
    logic [W-1:0]        res_min_value;
    logic [W-1:0]        res_max_value;
    logic [AW-1:0]       res_min_ref;
    logic [AW-1:0]       res_max_ref;
    logic                res_err;
    logic [31:0]         perf_cycles;

    int    checks;
    int    failures;
    item_t lq [NL][$];
    int    exp_xfer [$];
    res_t  exp_res [$];

    hsid_mse_arb #(
        .WORD_WIDTH       (W),
        .HSI_LIBRARY_SIZE (LS),
        .NUM_LANES        (NL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .lib_size      (lib_size),
        .busy          (busy),
        .done          (done),
        .lane_valid    (lane_valid),
        .lane_ready    (lane_ready),
        .lane_value    (lane_value),
        .lane_ref      (lane_ref),
        .cmp_clear     (cmp_clear),
        .cmp_in_valid  (cmp_in_valid),
        .cmp_in_value  (cmp_in_value),
        .cmp_in_ref    (cmp_in_ref),
        .cmp_out_valid (cmp_out_valid),
        .cmp_min_value (cmp_min_value),
        .cmp_max_value (cmp_max_value),
        .cmp_min_ref   (cmp_min_ref),
        .cmp_max_ref   (cmp_max_ref),
        .res_min_value (res_min_value),
        .res_max_value (res_max_value),
        .res_min_ref   (res_min_ref),
        .res_max_ref   (res_max_ref),
        .res_err       (res_err),
        .perf_cycles   (perf_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Behavioural comparator: clear has priority, strict compare keeps the first extreme
    initial begin
        cmp_out_valid = 1'b0;
        cmp_min_value = '1;
        cmp_max_value = '0;
        cmp_min_ref   = '0;
        cmp_max_ref   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || cmp_clear) begin
                cmp_min_value = '1;
                cmp_max_value = '0;
                cmp_min_ref   = '0;
                cmp_max_ref   = '0;
            end else if (cmp_in_valid) begin
                if (cmp_in_value < cmp_min_value) begin
                    cmp_min_value = cmp_in_value;
                    cmp_min_ref   = cmp_in_ref;
                end
                if (cmp_in_value > cmp_max_value) begin
                    cmp_max_value = cmp_in_value;
                    cmp_max_ref   = cmp_in_ref;
                end
            end
            cmp_out_valid = rst_n && cmp_in_valid;
        end
    end

    // Lane driver: present queue heads, pop a head once its handshake is due
    initial begin
        lane_valid = '0;
        lane_value = '0;
        lane_ref   = '0;
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NL; i++) begin
                if (lq[i].size() > 0) begin
                    lane_valid[i]          = 1'b1;
                    lane_value[i*W +: W]   = lq[i][0].v;
                    lane_ref[i*AW +: AW]   = lq[i][0].r;
                end else begin
                    lane_valid[i] = 1'b0;
                end
            end
            #1;
            for (int i = 0; i < NL; i++) begin
                if (lane_valid[i] && lane_ready[i]) begin
                    void'(lq[i].pop_front());
                end
            end
        end
    end

    // Transfer monitor: grant legality and expected grant order
    initial begin
        int e;
        forever begin
            @(negedge clk);
            #3;
            chk("ready_onehot0", 32'($onehot0(lane_ready)), 32'd1);
            for (int i = 0; i < NL; i++) begin
                if (lane_valid[i] && lane_ready[i]) begin
                    if (exp_xfer.size() == 0) begin
                        chk("unexpected_xfer_lane", i, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_xfer.pop_front();
                        chk("xfer_lane", i, e);
                    end
                end
            end
        end
    end

    // Result monitor: every done pulse pops one expected classification
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            #4;
            if (done) begin
                if (exp_res.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_res.pop_front();
                    chk("res_min_value", res_min_value, e.min_v);
                    chk("res_max_value", res_max_value, e.max_v);
                    chk("res_min_ref", 32'(res_min_ref), 32'(e.min_r));
                    chk("res_max_ref", 32'(res_max_ref), 32'(e.max_r));
                    chk("res_err", 32'(res_err), 32'(e.err));
                end
            end
        end
    end

    // Called at a negedge: pulse start across one rising edge
    task automatic start_pixel(input logic [AW:0] lib);
        start    = 1'b1;
        lib_size = lib;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Cycles counted with the start cycle as 0; returns at the done negedge
    task automatic wait_done(input string name, input int exp_lat);
        int cnt;
        cnt = 1;
        while (!done && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        chk(name, cnt, exp_lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done_seen;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        lib_size = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cmp_clear", 32'(cmp_clear), 32'd0);
        chk("rst_cmp_in_valid", 32'(cmp_in_valid), 32'd0);
        chk("rst_res_min_value", res_min_value, 32'hFFFF_FFFF);
        chk("rst_res_max_value", res_max_value, 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        chk("rst_perf", perf_cycles, 32'd0);

        // Fairness: all lanes requesting, pointer from reset
        lq[0].push_back('{32'd100, 4'd0}); lq[0].push_back('{32'd50,  4'd4});
        lq[1].push_back('{32'd200, 4'd1}); lq[1].push_back('{32'd30,  4'd5});
        lq[2].push_back('{32'd10,  4'd2}); lq[2].push_back('{32'd300, 4'd6});
        lq[3].push_back('{32'd400, 4'd3}); lq[3].push_back('{32'd60,  4'd7});
        for (int k = 0; k < 8; k++) exp_xfer.push_back(k % 4);
        exp_res.push_back('{32'd10, 32'd400, 4'd2, 4'd3, 1'b0});
        start_pixel(5'd8);
        chk("fair_busy", 32'(busy), 32'd1);
        wait_done("fair_latency", 12);
        @(negedge clk);

        // Single lane
        lq[0].push_back('{32'h0000_FFFF, 4'd1});
        lq[0].push_back('{32'h000F_FFFF, 4'd2});
        lq[0].push_back('{32'h0000_0FFF, 4'd3});
        repeat (3) exp_xfer.push_back(0);
        exp_res.push_back('{32'h0000_0FFF, 32'h000F_FFFF, 4'd3, 4'd2, 1'b0});
        start_pixel(5'd3);
        wait_done("single_latency", 7);
`ifdef HSID_MSE_ARB_PERF_EN
        chk("perf_cycles", perf_cycles, 32'd6);
`else
        chk("perf_cycles_tied", perf_cycles, 32'd0);
`endif
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Zero size
        exp_res.push_back('{32'hFFFF_FFFF, 32'd0, 4'd0, 4'd0, 1'b1});
        start_pixel(5'd0);
        wait_done("zero_latency", 2);
        @(negedge clk);

        // Saturation: 20 offered, only LS may transfer
        for (int k = 0; k < 20; k++) begin
            lq[1].push_back('{(k == 5) ? 32'd7 : 32'(500 + k), 4'(k)});
        end
        repeat (LS) exp_xfer.push_back(1);
        exp_res.push_back('{32'd7, 32'd515, 4'd5, 4'd15, 1'b1});
        start_pixel(5'(LS + 5));
        wait_done("sat_latency", LS + 4);
        chk("sat_leftover", lq[1].size(), 32'd4);
        lq[1].delete();
        @(negedge clk);

        // Back-to-back: second start issued in the done cycle
        lq[2].push_back('{32'h500, 4'd9});
        lq[2].push_back('{32'h600, 4'd10});
        exp_xfer.push_back(2); exp_xfer.push_back(2);
        exp_res.push_back('{32'h500, 32'h600, 4'd9, 4'd10, 1'b0});
        start_pixel(5'd2);
        wait_done("b2b_a_latency", 6);
        lq[3].push_back('{32'h20, 4'd1});
        lq[3].push_back('{32'h10, 4'd2});
        exp_xfer.push_back(3); exp_xfer.push_back(3);
        exp_res.push_back('{32'h10, 32'h20, 4'd2, 4'd1, 1'b0});
        start_pixel(5'd2);
        chk("b2b_cmp_clear", 32'(cmp_clear), 32'd1);
        wait_done("b2b_b_latency", 6);
        @(negedge clk);

        // Abort mid-RUN: two transfers complete, then reset
        for (int k = 0; k < 8; k++) lq[0].push_back('{32'(k + 1), 4'(k)});
        exp_xfer.push_back(0); exp_xfer.push_back(0);
        start_pixel(5'd8);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        lq[0].delete();
        #1;
        chk("abort_ready_in_rst", 32'(lane_ready), 32'd0);
        chk("abort_busy_in_rst", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        chk("abort_ready", 32'(lane_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cmp_in_valid", 32'(cmp_in_valid), 32'd0);
        chk("abort_res_min_value", res_min_value, 32'hFFFF_FFFF);
        chk("abort_res_max_value", res_max_value, 32'd0);
        chk("abort_res_err", 32'(res_err), 32'd0);
        chk("abort_perf", perf_cycles, 32'd0);

        chk("xfer_queue_empty", exp_xfer.size(), 32'd0);
        chk("res_queue_empty", exp_res.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
